wb_stage: RTL
=============

// Module: wb_stage
// PURPOSE
//   Write-back stage of the five-stage MIPS pipeline; consumes the 118-bit MEM->WB bus.
//   Holds HI/LO and the CP0 STATUS/CAUSE/EPC registers, resolves mfhi/mflo/mfc0 results,
//   drives the register-file write port, and raises SYSCALL/ERET redirects that flush upstream stages.
//   Keeps a retired-instruction counter for the display.
// PARAMETERS
//   EXC_ENTRY   32'h0000_0000  redirect target PC for SYSCALL
//   SYS_EXCCODE 5'd8           CAUSE.ExcCode written on SYSCALL
// PORTS
//   clk           in   1    clock
//   rst           in   1    synchronous reset, active-high
//   WB_valid      in   1    WB stage holds a valid instruction this cycle
//   MEM_WB_bus_r  in   118  {rf_wen,rf_wdest[4:0],mem_result[31:0],lo_result[31:0],hi_write,lo_write,
//                            mfhi,mflo,mtc0,mfc0,cp0r_addr[7:0],syscall,eret,pc[31:0]}, MSB first
//   rf_wen        out  1    register-file write enable
//   rf_wdest      out  5    register-file write address
//   rf_wdata      out  32   register-file write data
//   WB_over       out  1    WB done this cycle
//   WB_wdest      out  5    pending dest for hazard check, 0 when invalid
//   exc_valid     out  1    redirect request (SYSCALL or ERET)
//   exc_pc        out  32   redirect target
//   cancel        out  1    flush IF/ID/EXE/MEM
//   WB_pc         out  32   PC of WB instruction (display)
//   HI_data       out  32   current HI
//   LO_data       out  32   current LO
//   inst_count    out  32   retired-instruction count
// BEHAVIOUR
// - Single-cycle stage: WB_over = WB_valid; WB never stalls.
// - Reset values: HI=0, LO=0, STATUS=0, CAUSE=0, EPC=0, inst_count=0.
// - Reset outputs: combinational outputs follow from WB_valid; bench drives WB_valid=0 during rst.
// - Combinational outputs:
//   - rf_wen = WB_valid & bus.rf_wen & ~syscall.
//   - WB_wdest = rf_wdest & {5{WB_valid}}.
//   - WB_pc = bus.pc.
// - rf_wdata priority:
//   - mfhi -> HI
//   - mflo -> LO
//   - mfc0 -> selected CP0 reg
//   - else mem_result
//   HI/LO/CP0 values are register outputs of the current cycle.
// - CP0 selection by cp0r_addr = {rd,sel}:
//   - {5'd12,3'd0} STATUS
//   - {5'd13,3'd0} CAUSE
//   - {5'd14,3'd0} EPC
//   - other addresses read 0; mtc0 to them is ignored.
// - Updates at posedge clk, only when WB_valid=1:
//   - hi_write -> HI <= mem_result.
//   - lo_write -> LO <= lo_result.
//   - Both set in one instruction (mult) -> both update.
//   - mtc0 -> selected reg <= mem_result.
//     - STATUS writes all 32 bits.
//     - CAUSE writable bits: [9:8] only.
//     - EPC writes all 32 bits.
//   - syscall:
//     - EPC <= pc; STATUS[1] (EXL) <= 1; CAUSE[6:2] <= SYS_EXCCODE.
//     - Other CAUSE bits unchanged.
//   - eret -> STATUS[1] <= 0.
//   - inst_count <= inst_count+1; wraps 32'hFFFF_FFFF -> 0.
// - Redirect (combinational):
//   - exc_valid = WB_valid & (syscall|eret).
//   - exc_pc = syscall ? EXC_ENTRY : EPC. ERET uses EPC value before this edge.
//   - cancel = exc_valid.
// - Boundary cases:
//   - mtc0 EPC immediately followed by eret (next cycle): eret sees the new EPC.
//   - syscall and eret both set: syscall wins; eret ignored.
//   - WB_valid=0: no state changes; rf_wen=0, exc_valid=0, cancel=0.
//   - rst asserted mid-sequence: all registers return to reset values at that edge, and the
//     instruction present that cycle is discarded. Outputs still reflect the bus combinationally.
// TESTING
// - mult-style bus (hi_write=lo_write=1, mem_result=32'h1234_5678, lo_result=32'h9ABC_DEF0),
//   next cycle mfhi rf_wen=1 rf_wdest=3 -> rf_wdata=32'h1234_5678;
//   then mflo -> rf_wdata=32'h9ABC_DEF0.
// - syscall pc=32'h0000_0040 ->
//   - same cycle: exc_valid=1, cancel=1, exc_pc=0, rf_wen=0.
//   - next cycle: EPC=0x40, STATUS[1]=1, CAUSE[6:2]=8.
// - mtc0 EPC (cp0r_addr=8'h70) data 32'h0000_0100, then eret next cycle ->
//   exc_pc=32'h0000_0100, STATUS[1]=0 after edge.
// - mfc0 from cp0r_addr=8'h68 after syscall -> rf_wdata=32'h0000_0020;
//   mtc0 CAUSE with 32'hFFFF_FFFF -> CAUSE=32'h0000_0320.
// - Preload inst_count near wrap: 5 valid cycles from reset -> inst_count=5;
//   WB_valid=0 cycles don't count; assert rst mid-run -> inst_count=0, HI=LO=0.

Source files
------------

// File: rtl/wb_stage_if.sv
// MEM->WB bus plus write-back stage results, bundled for the wb_stage port list.
// The master side drives the instruction in; the slave side is the WB stage itself.
interface wb_stage_if;
  logic         WB_valid;
  logic [117:0] MEM_WB_bus_r;
  logic         rf_wen;
  logic [4:0]   rf_wdest;
  logic [31:0]  rf_wdata;
  logic         WB_over;
  logic [4:0]   WB_wdest;
  logic         exc_valid;
  logic [31:0]  exc_pc;
  logic         cancel;
  logic [31:0]  WB_pc;
  logic [31:0]  HI_data;
  logic [31:0]  LO_data;
  logic [31:0]  inst_count;

  modport master (
    output WB_valid, MEM_WB_bus_r,
    input  rf_wen, rf_wdest, rf_wdata, WB_over, WB_wdest, exc_valid, exc_pc,
           cancel, WB_pc, HI_data, LO_data, inst_count
  );

  modport slave (
    input  WB_valid, MEM_WB_bus_r,
    output rf_wen, rf_wdest, rf_wdata, WB_over, WB_wdest, exc_valid, exc_pc,
           cancel, WB_pc, HI_data, LO_data, inst_count
  );
endinterface

// File: rtl/wb_stage.sv
// MIPS write-back stage: HI/LO and CP0 STATUS/CAUSE/EPC state, register-file write port,
// SYSCALL/ERET redirect generation and a retired-instruction counter.
module wb_stage #(
  parameter logic [31:0] EXC_ENTRY   = 32'h0000_0000,
  parameter logic [4:0]  SYS_EXCCODE = 5'd8
) (
  input  logic       clk,
  input  logic       rst,
  wb_stage_if.slave  wb
);

  localparam logic [7:0] CP0_STATUS = {5'd12, 3'd0};
  localparam logic [7:0] CP0_CAUSE  = {5'd13, 3'd0};
  localparam logic [7:0] CP0_EPC    = {5'd14, 3'd0};

  // Only the software-interrupt bits IP[1:0] of CAUSE are writable by mtc0.
  function automatic logic [31:0] cause_mtc0(input logic [31:0] old_v, input logic [31:0] wr_v);
    cause_mtc0 = {old_v[31:10], wr_v[9:8], old_v[7:0]};
  endfunction

  logic        w_rf_wen;
  logic [4:0]  w_rf_wdest;
  logic [31:0] w_mem_result;
  logic [31:0] w_lo_result;
  logic        w_hi_write;
  logic        w_lo_write;
  logic        w_mfhi;
  logic        w_mflo;
  logic        w_mtc0;
  logic        w_mfc0;
  logic [7:0]  w_cp0r_addr;
  logic        w_syscall;
  logic        w_eret;
  logic [31:0] w_pc;

  assign {w_rf_wen, w_rf_wdest, w_mem_result, w_lo_result, w_hi_write, w_lo_write,
          w_mfhi, w_mflo, w_mtc0, w_mfc0, w_cp0r_addr, w_syscall, w_eret, w_pc} = wb.MEM_WB_bus_r;

  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic [31:0] r_status;
  logic [31:0] r_cause;
  logic [31:0] r_epc;
  logic [31:0] r_inst_count;

  logic [31:0] w_cp0_rdata;
  logic [31:0] w_rf_wdata;
  logic [31:0] w_status_nxt;
  logic [31:0] w_cause_nxt;
  logic [31:0] w_epc_nxt;
  logic        w_exc_valid;

  always_comb begin
    case (w_cp0r_addr)
      CP0_STATUS: w_cp0_rdata = r_status;
      CP0_CAUSE:  w_cp0_rdata = r_cause;
      CP0_EPC:    w_cp0_rdata = r_epc;
      default:    w_cp0_rdata = 32'h0000_0000;
    endcase
  end

  always_comb begin
    if (w_mfhi)      w_rf_wdata = r_hi;
    else if (w_mflo) w_rf_wdata = r_lo;
    else if (w_mfc0) w_rf_wdata = w_cp0_rdata;
    else             w_rf_wdata = w_mem_result;
  end

  // SYSCALL is applied after mtc0 so the exception entry state wins; ERET is ignored alongside it.
  always_comb begin
    w_status_nxt = r_status;
    w_cause_nxt  = r_cause;
    w_epc_nxt    = r_epc;
    if (w_mtc0) begin
      case (w_cp0r_addr)
        CP0_STATUS: w_status_nxt = w_mem_result;
        CP0_CAUSE:  w_cause_nxt  = cause_mtc0(r_cause, w_mem_result);
        CP0_EPC:    w_epc_nxt    = w_mem_result;
        default:    ;
      endcase
    end
    if (w_syscall) begin
      w_epc_nxt         = w_pc;
      w_status_nxt[1]   = 1'b1;
      w_cause_nxt[6:2]  = SYS_EXCCODE;
    end else if (w_eret) begin
      w_status_nxt[1]   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hi         <= 32'h0;
      r_lo         <= 32'h0;
      r_status     <= 32'h0;
      r_cause      <= 32'h0;
      r_epc        <= 32'h0;
      r_inst_count <= 32'h0;
    end else if (wb.WB_valid) begin
      if (w_hi_write) r_hi <= w_mem_result;
      if (w_lo_write) r_lo <= w_lo_result;
      r_status     <= w_status_nxt;
      r_cause      <= w_cause_nxt;
      r_epc        <= w_epc_nxt;
      r_inst_count <= r_inst_count + 32'd1;
    end
  end

  assign w_exc_valid   = wb.WB_valid & (w_syscall | w_eret);

  assign wb.rf_wen     = wb.WB_valid & w_rf_wen & ~w_syscall;
  assign wb.rf_wdest   = w_rf_wdest;
  assign wb.rf_wdata   = w_rf_wdata;
  assign wb.WB_over    = wb.WB_valid;
  assign wb.WB_wdest   = w_rf_wdest & {5{wb.WB_valid}};
  assign wb.exc_valid  = w_exc_valid;
  assign wb.exc_pc     = w_syscall ? EXC_ENTRY : r_epc;
  assign wb.cancel     = w_exc_valid;
  assign wb.WB_pc      = w_pc;
  assign wb.HI_data    = r_hi;
  assign wb.LO_data    = r_lo;
  assign wb.inst_count = r_inst_count;

endmodule
